// File: rtl/metronome_core.sv
// metronome_core: BPM holder with button auto-repeat, phase-accumulator beat
// generator, measure sequencer with per-beat mask and accent, and a
// sequential binary-to-BCD converter for the seven-segment display.
module metronome_core #(
    parameter int CLK_HZ          = 50000000,
    parameter int BPM_MIN         = 20,
    parameter int BPM_MAX         = 300,
    parameter int BPM_INIT        = 60,
    parameter int MAX_BEATS       = 8,
    parameter int BEAT_W          = 3,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int CLICK_MS        = 50
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 run_i,
    input  logic [BEAT_W:0]      beats_i,
    input  logic [MAX_BEATS-1:0] beat_mask_i,
    input  logic                 inc_n_i,
    input  logic                 dec_n_i,
    output logic [9:0]           bpm_o,
    output logic [11:0]          bpm_bcd_o,
    output logic [BEAT_W-1:0]    beat_idx_o,
    output logic                 tick_o,
    output logic                 click_o,
    output logic                 accent_o
);

    // Derived timing constants, computed in 64 bits because CLK_HZ*60
    // overflows a 32-bit int at realistic clock rates.
    localparam longint LIMIT_L   = longint'(CLK_HZ) * 60;
    localparam int     ACC_W     = $clog2(LIMIT_L + BPM_MAX);
    localparam longint DELAY_L   = longint'(REPEAT_DELAY_MS) * CLK_HZ / 1000;
    localparam longint RATE_L    = longint'(REPEAT_RATE_MS) * CLK_HZ / 1000;
    localparam longint CLICK_L   = longint'(CLICK_MS) * CLK_HZ / 1000;
    localparam longint RPT_MAX_L = (DELAY_L > RATE_L) ? DELAY_L : RATE_L;
    localparam int     RPT_W     = (RPT_MAX_L < 1) ? 1 : $clog2(RPT_MAX_L + 1);
    localparam int     CLICK_W   = (CLICK_L < 2) ? 1 : $clog2(CLICK_L + 1);

    localparam logic [ACC_W-1:0]   LIMIT_V      = ACC_W'(LIMIT_L);
    localparam logic [RPT_W-1:0]   DELAY_V      = RPT_W'(DELAY_L);
    localparam logic [RPT_W-1:0]   RATE_V       = RPT_W'(RATE_L);
    localparam logic [CLICK_W-1:0] CLICK_LAST_V = CLICK_W'(CLICK_L - 1);
    localparam logic [9:0]         BPM_MIN_V    = 10'(BPM_MIN);
    localparam logic [9:0]         BPM_MAX_V    = 10'(BPM_MAX);
    localparam logic [9:0]         BPM_INIT_V   = 10'(BPM_INIT);
    localparam logic [BEAT_W:0]    MAX_BEATS_V  = (BEAT_W+1)'(MAX_BEATS);

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_DELAY  = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_e;

    genvar gi;

    // ------------------------------------------------------------------
    // Buttons: index 0 = increment, index 1 = decrement
    // ------------------------------------------------------------------
    logic [1:0] btn_n;
    logic       both_low;
    logic [1:0] step;

    assign btn_n    = {dec_n_i, inc_n_i};
    assign both_low = ~inc_n_i & ~dec_n_i;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_state_e       state_reg, state_next;
            logic [RPT_W-1:0] cnt_reg, cnt_next;
            logic             step_now;

            // Button FSM state and low-time counter
            always_ff @(posedge clock_i) begin
                if (!reset_n_i) begin
                    state_reg <= BTN_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Step decision: immediate step, one after the hold delay, then periodic
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                step_now   = 1'b0;
                if (btn_n[gi] || both_low) begin
                    state_next = BTN_IDLE;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        BTN_IDLE: begin
                            step_now   = 1'b1;
                            state_next = BTN_DELAY;
                            cnt_next   = RPT_W'(1);
                        end
                        BTN_DELAY: begin
                            if (cnt_reg >= DELAY_V) begin
                                step_now   = 1'b1;
                                state_next = BTN_REPEAT;
                                cnt_next   = RPT_W'(1);
                            end else begin
                                cnt_next = cnt_reg + RPT_W'(1);
                            end
                        end
                        BTN_REPEAT: begin
                            if (cnt_reg >= RATE_V) begin
                                step_now = 1'b1;
                                cnt_next = RPT_W'(1);
                            end else begin
                                cnt_next = cnt_reg + RPT_W'(1);
                            end
                        end
                        default: begin
                            state_next = BTN_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign step[gi] = step_now;
        end
    endgenerate

    // ------------------------------------------------------------------
    // BPM register
    // ------------------------------------------------------------------
    logic [9:0] bpm_reg, bpm_next;

    // Saturating single-step adjust; the FSMs never step both at once
    always_comb begin
        bpm_next = bpm_reg;
        if (step[0] && (bpm_reg < BPM_MAX_V)) begin
            bpm_next = bpm_reg + 10'd1;
        end else if (step[1] && (bpm_reg > BPM_MIN_V)) begin
            bpm_next = bpm_reg - 10'd1;
        end
    end

    // BPM state
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            bpm_reg <= BPM_INIT_V;
        end else begin
            bpm_reg <= bpm_next;
        end
    end

    // ------------------------------------------------------------------
    // Binary to BCD: one shift-add-3 iteration per cycle, 10 iterations
    // ------------------------------------------------------------------
    logic [21:0] dd_reg;
    logic [11:0] dd_adj;
    logic [21:0] dd_shift;
    logic [3:0]  dd_cnt_reg;
    logic        conv_busy_reg;
    logic [9:0]  src_reg;
    logic        src_valid_reg;
    logic [11:0] bcd_reg;
    logic        conv_start;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_dabble
            assign dd_adj[4*gi +: 4] = (dd_reg[10+4*gi +: 4] >= 4'd5)
                                     ? dd_reg[10+4*gi +: 4] + 4'd3
                                     : dd_reg[10+4*gi +: 4];
        end
    endgenerate

    assign dd_shift   = {dd_adj, dd_reg[9:0]} << 1;
    // A new or changed BPM value (including the first after reset) restarts
    // the conversion, even one already in progress.
    assign conv_start = !src_valid_reg || (bpm_reg != src_reg);

    // Converter sequencing; the displayed value only changes on completion
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            dd_reg        <= '0;
            dd_cnt_reg    <= '0;
            conv_busy_reg <= 1'b0;
            src_reg       <= '0;
            src_valid_reg <= 1'b0;
            bcd_reg       <= '0;
        end else if (conv_start) begin
            dd_reg        <= {12'd0, bpm_reg};
            dd_cnt_reg    <= '0;
            conv_busy_reg <= 1'b1;
            src_reg       <= bpm_reg;
            src_valid_reg <= 1'b1;
        end else if (conv_busy_reg) begin
            dd_reg     <= dd_shift;
            dd_cnt_reg <= dd_cnt_reg + 4'd1;
            if (dd_cnt_reg == 4'd9) begin
                bcd_reg       <= dd_shift[21:10];
                conv_busy_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat generator and measure sequencer
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   acc_sum;
    logic               wrap;
    logic               start_reg;
    logic               tick_reg;
    logic [BEAT_W-1:0]  idx_reg;
    logic               click_reg;
    logic               accent_reg;
    logic [CLICK_W-1:0] click_cnt_reg;
    logic [BEAT_W:0]    beats_eff;
    logic [BEAT_W:0]    idx_inc;
    logic [BEAT_W-1:0]  idx_next;
    logic               tick_next;

    assign acc_sum = acc_reg + ACC_W'(bpm_reg);
    assign wrap    = (acc_sum >= LIMIT_V);
    assign idx_inc = {1'b0, idx_reg} + (BEAT_W+1)'(1);

    // Effective beat count, next index and whether a beat starts this cycle
    always_comb begin
        beats_eff = beats_i;
        if (beats_i == '0) begin
            beats_eff = (BEAT_W+1)'(1);
        end else if (beats_i > MAX_BEATS_V) begin
            beats_eff = MAX_BEATS_V;
        end
        idx_next  = idx_reg;
        tick_next = 1'b0;
        if (start_reg) begin
            tick_next = 1'b1;
            idx_next  = '0;
        end else if (wrap) begin
            tick_next = 1'b1;
            idx_next  = (idx_inc >= beats_eff) ? '0 : idx_inc[BEAT_W-1:0];
        end
    end

    // Phase accumulator, start flag, tick and beat index
    always_ff @(posedge clock_i) begin
        if (!reset_n_i || !run_i) begin
            acc_reg   <= '0;
            start_reg <= 1'b1;
            tick_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            tick_reg <= tick_next;
            idx_reg  <= idx_next;
            if (start_reg) begin
                start_reg <= 1'b0;
            end else if (wrap) begin
                acc_reg <= acc_sum - LIMIT_V;
            end else begin
                acc_reg <= acc_sum;
            end
        end
    end

    // Click span: (re)armed by an audible tick, cut by a silent tick
    always_ff @(posedge clock_i) begin
        if (!reset_n_i || !run_i) begin
            click_reg     <= 1'b0;
            accent_reg    <= 1'b0;
            click_cnt_reg <= '0;
        end else if (tick_next) begin
            if (beat_mask_i[idx_next]) begin
                click_reg     <= 1'b1;
                accent_reg    <= (idx_next == '0);
                click_cnt_reg <= CLICK_LAST_V;
            end else begin
                click_reg     <= 1'b0;
                accent_reg    <= 1'b0;
                click_cnt_reg <= '0;
            end
        end else if (click_reg) begin
            if (click_cnt_reg == '0) begin
                click_reg  <= 1'b0;
                accent_reg <= 1'b0;
            end else begin
                click_cnt_reg <= click_cnt_reg - CLICK_W'(1);
            end
        end
    end

    assign bpm_o      = bpm_reg;
    assign bpm_bcd_o  = bcd_reg;
    assign beat_idx_o = idx_reg;
    assign tick_o     = tick_reg;
    assign click_o    = click_reg;
    assign accent_o   = accent_reg;

endmodule

// File: tb/tb_metronome_core.sv
module tb_metronome_core;
    localparam int CLK_HZ    = 1000;
    localparam int MAX_BEATS = 8;
    localparam int BEAT_W    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 run;
    logic [BEAT_W:0]      beats;
    logic [MAX_BEATS-1:0] mask;
    logic                 inc_n;
    logic                 dec_n;

    logic [9:0]        bpm_a, bpm_b;
    logic [11:0]       bcd_a, bcd_b;
    logic [BEAT_W-1:0] idx_a, idx_b;
    logic              tick_a, tick_b, click_a, click_b, accent_a, accent_b;

    int n_checks = 0;
    int n_fail   = 0;
    int seg_idx[8] = '{0, 1, 2, 0, 1, 2, 0, 0};

    metronome_core #(.CLK_HZ(CLK_HZ), .CLICK_MS(50)) u_dut_a (
        .clock_i(clk), .reset_n_i(reset_n), .run_i(run), .beats_i(beats),
        .beat_mask_i(mask), .inc_n_i(inc_n), .dec_n_i(dec_n),
        .bpm_o(bpm_a), .bpm_bcd_o(bcd_a), .beat_idx_o(idx_a),
        .tick_o(tick_a), .click_o(click_a), .accent_o(accent_a)
    );

    metronome_core #(.CLK_HZ(CLK_HZ), .CLICK_MS(250)) u_dut_b (
        .clock_i(clk), .reset_n_i(reset_n), .run_i(run), .beats_i(beats),
        .beat_mask_i(mask), .inc_n_i(inc_n), .dec_n_i(dec_n),
        .bpm_o(bpm_b), .bpm_bcd_o(bcd_b), .beat_idx_o(idx_b),
        .tick_o(tick_b), .click_o(click_b), .accent_o(accent_b)
    );

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("PASS %s: %0h", tag, obs);
        end
    endtask

    initial begin
        logic       e_tick, e_click, e_acc;
        logic [2:0] e_idx;
        int         e_bpm;

        reset_n = 1'b0; run = 1'b0; inc_n = 1'b1; dec_n = 1'b1;
        beats = 4'd4; mask = 8'h0F;
        @(negedge clk);
        cycles(3);
        reset_n = 1'b1;

        chk("reset_bpm", bpm_a, 10'd60);
        chk("reset_tick", tick_a, 1'b0);
        chk("reset_click", click_a, 1'b0);
        chk("reset_accent", accent_a, 1'b0);
        chk("reset_idx", idx_a, 3'd0);
        cycles(12);
        chk("reset_bcd_a", bcd_a, 12'h060);
        chk("reset_bcd_b", bcd_b, 12'h060);

        run = 1'b1;
        for (int k = 0; k <= 4000; k++) begin
            cycles(1);
            e_tick  = ((k % 1000) == 0);
            e_idx   = 3'((k / 1000) % 4);
            e_click = ((k % 1000) < 50);
            e_acc   = e_click && (e_idx == 3'd0);
            chk("t2_tick", tick_a, e_tick);
            chk("t2_idx", idx_a, e_idx);
            chk("t2_click", click_a, e_click);
            chk("t2_accent", accent_a, e_acc);
        end
        run = 1'b0;
        cycles(1);
        chk("stop_click", click_a, 1'b0);
        chk("stop_accent", accent_a, 1'b0);
        chk("stop_idx", idx_a, 3'd0);
        chk("stop_tick", tick_a, 1'b0);

        inc_n = 1'b0;
        cycles(10);
        inc_n = 1'b1;
        cycles(12);
        chk("inc_tap_bpm", bpm_a, 10'd61);
        chk("inc_tap_bcd", bcd_a, 12'h061);

        dec_n = 1'b0;
        for (int j = 0; j < 800; j++) begin
            cycles(1);
            e_bpm = 60 - ((j >= 500) ? 1 : 0) - ((j >= 600) ? 1 : 0) - ((j >= 700) ? 1 : 0);
            chk("dec_hold_bpm", bpm_a, 10'(e_bpm));
        end
        dec_n = 1'b1;
        cycles(12);
        chk("dec_hold_end", bpm_a, 10'd57);
        chk("dec_hold_bcd", bcd_a, 12'h057);

        inc_n = 1'b0;
        cycles(25000);
        inc_n = 1'b1;
        cycles(12);
        chk("max_bpm", bpm_a, 10'd300);
        chk("max_bcd", bcd_a, 12'h300);
        inc_n = 1'b0;
        cycles(10);
        inc_n = 1'b1;
        cycles(2);
        chk("max_inc_tap", bpm_a, 10'd300);

        inc_n = 1'b0; dec_n = 1'b0;
        for (int j = 0; j < 1000; j++) begin
            cycles(1);
            chk("both_low_bpm", bpm_a, 10'd300);
        end
        inc_n = 1'b1; dec_n = 1'b1;
        cycles(2);
        chk("both_release_bpm", bpm_a, 10'd300);

        run = 1'b1;
        for (int k = 0; k <= 450; k++) begin
            cycles(1);
            e_tick = ((k % 200) == 0);
            e_idx  = 3'((k / 200) % 4);
            chk("t6_tick", tick_b, e_tick);
            chk("t6_idx", idx_b, e_idx);
            chk("t6_click", click_b, 1'b1);
            chk("t6_accent", accent_b, (e_idx == 3'd0));
        end
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        chk("midclick_rst_bpm", bpm_b, 10'd60);
        chk("midclick_rst_click", click_b, 1'b0);
        chk("midclick_rst_accent", accent_b, 1'b0);
        chk("midclick_rst_tick", tick_b, 1'b0);
        chk("midclick_rst_idx", idx_b, 3'd0);
        chk("midclick_rst_bpm_a", bpm_a, 10'd60);
        run = 1'b0;
        cycles(12);
        chk("midclick_rst_bcd", bcd_b, 12'h060);

        mask = 8'h05; beats = 4'd4;
        run = 1'b1;
        for (int k = 0; k <= 7000; k++) begin
            cycles(1);
            e_tick  = ((k % 1000) == 0);
            e_idx   = 3'(seg_idx[k / 1000]);
            e_click = ((k % 1000) < 50) && ((e_idx == 3'd0) || (e_idx == 3'd2));
            e_acc   = e_click && (e_idx == 3'd0);
            chk("t5_tick", tick_a, e_tick);
            chk("t5_idx", idx_a, e_idx);
            chk("t5_click", click_a, e_click);
            chk("t5_accent", accent_a, e_acc);
            if (k == 2500) beats = 4'd2;
            if (k == 4500) beats = 4'd15;
            if (k == 5500) beats = 4'd0;
        end
        run = 1'b0;
        cycles(1);

        dec_n = 1'b0;
        cycles(5000);
        dec_n = 1'b1;
        cycles(12);
        chk("min_bpm", bpm_a, 10'd20);
        chk("min_bcd", bcd_a, 12'h020);
        dec_n = 1'b0;
        cycles(10);
        dec_n = 1'b1;
        cycles(2);
        chk("min_dec_tap", bpm_a, 10'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
